usb_kbd_report_sched: RTL and testbench
=======================================

Name: usb_kbd_report_sched

Overview:
- Schedules and shares the single HID keyboard IN endpoint (EP81, 8-byte boot reports) among NREQ key requesters.
- Each accepted key event becomes a press report, an enforced gap, a release report (all zeros) and a second gap.
- Sits between application key sources and the usbfs core EP81 stream port (data/valid/ready).
- Replaces ad-hoc single-source report shifting.

Parameters:
- NREQ, 4, number of requesters (2..8).
- GAP_CYCLES, 60000, idle clk cycles enforced after each report (1 ms at 60 MHz); minimum 1.

Ports:
- clk  in  1  60 MHz system clock.
- rstn  in  1  asynchronous active-low reset.
- link_up  in  1  USB connected (core usb_rstn); 0 = synchronous abort/flush.
- req_valid  in  NREQ  per-requester key event pending.
- req_key  in  16*NREQ  per requester: [15:8] modifier byte, [7:0] keycode (HID usage, not ASCII).
- req_ready  out  NREQ  one-hot, 1-cycle accept pulse.
- ep_data  out  8  report byte to EP81.
- ep_valid  out  1  report byte valid; held high for the whole report.
- ep_ready  in  1  EP81 consumed current byte.
- busy  out  1  state != IDLE.
- grant_idx  out  $clog2(NREQ)  index of last granted requester.

Behaviour:
- Reset (rstn=0, async): state IDLE, ep_valid=0, ep_data=0, req_ready=0, busy=0, grant_idx=0, rr pointer=0, byte count=0, gap count=0.
- States: IDLE, PRESS, GAP1, RELEASE, GAP2.
- IDLE, link_up=1, any req_valid:
  - Round-robin grant: first set bit at or after the pointer, wrapping.
  - That requester's req_ready pulses 1 cycle. Key is latched and grant_idx updated.
  - Pointer = (grant+1) mod NREQ.
  - Next state PRESS, or GAP2 if the latched key is 16'h0000 (empty event: consumed, no reports, gap still applied).
  - Latency: req_valid high in IDLE -> req_ready same cycle (combinational from registered state) -> ep_valid high the next cycle.
- PRESS report bytes 0..7: modifier, 8'h00, keycode, 8'h00 x5.
  - ep_valid=1 throughout; byte index advances only on ep_valid & ep_ready.
  - ep_ready low stalls indefinitely with ep_data stable.
  - After byte 7 is accepted: ep_valid=0 the next cycle, state GAP1.
- GAP1 / GAP2: count GAP_CYCLES clocks with ep_valid=0.
  - GAP1 -> RELEASE; GAP2 -> IDLE.
  - A new grant is possible on the first IDLE cycle.
- RELEASE: 8 bytes of 8'h00, same handshake as PRESS, then GAP2.
- req_ready is never asserted outside IDLE. Requesters keep req_valid/req_key stable until their req_ready.
- link_up=0 in any state: next cycle state IDLE, ep_valid=0, counters cleared, the in-flight key is discarded, no grants. The rr pointer is kept. Grants resume on the first cycle link_up=1.
- req_valid deasserted before grant: no effect. Simultaneous requests: strictly round-robin, no requester starves; worst-case wait is NREQ-1 events.
- Counters: byte index 3 bits, gap counter $clog2(GAP_CYCLES+1) bits. No wrap beyond the terminal values.

Optional Feature:
- Macro USB_KBD_REPORT_CNT_EN.
- Defined: extra output report_cnt [15:0]. Increments by 1 when PRESS byte 7 is accepted, saturates at 16'hFFFF, reset to 0 only by rstn (not by link_up).
- Undefined: port and counter absent; other behaviour identical.

Decomposition:
- Package usb_kbd_pkg:
  - state enum (IDLE, PRESS, GAP1, RELEASE, GAP2)
  - REPORT_LEN=8
  - byte offsets MOD_BYTE=0, KEY_BYTE=2
  - key struct {modifier, keycode}
- Sub-module usb_kbd_rr_arbiter, parameterised NREQ:
  - inputs req vector and enable; outputs one-hot grant and index.
  - owns the pointer, advanced on grant.

Test Plan (GAP_CYCLES=4, NREQ=4):
- Single event: req 0 key 16'h0204 (shift+'a'), ep_ready=1 -> ep_data 02,00,04,00,00,00,00,00; then 4 idle cycles; then eight 00 bytes; busy falls after 4 more cycles.
- Contention: req_valid=4'b1011 held -> grants in order 0,1,3,0. req_ready one-hot each time. Each report pair is complete before the next grant.
- Backpressure: ep_ready toggling 1,0,0,1 during PRESS -> ep_data holds on stall cycles, ep_valid never drops mid-report, exactly 8 accepted bytes.
- Empty key 16'h0000 on req 2 -> req_ready[2] pulses, no ep_valid, IDLE after GAP2 (4 cycles).
- Abort: link_up=0 at PRESS byte 3 -> ep_valid=0 next cycle, state IDLE. Restoring link_up with req 1 pending -> fresh PRESS starting at byte 0.
- With USB_KBD_REPORT_CNT_EN: three events -> report_cnt=3. Force the counter to 16'hFFFF, send one more event -> stays 16'hFFFF. A link_up pulse -> unchanged.

Source files
------------

// File: rtl/usb_kbd_pkg.sv
// Shared types and constants for the EP81 boot-keyboard report scheduler.
package usb_kbd_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PRESS   = 3'd1,
        GAP1    = 3'd2,
        RELEASE = 3'd3,
        GAP2    = 3'd4
    } state_t;

    localparam int         REPORT_LEN = 8;
    localparam logic [2:0] MOD_BYTE   = 3'd0;
    localparam logic [2:0] KEY_BYTE   = 3'd2;

    typedef struct packed {
        logic [7:0] modifier;
        logic [7:0] keycode;
    } key_t;

    // Byte idx of an 8-byte boot press report: modifier, reserved, keycode, 5 empty slots.
    function automatic logic [7:0] press_byte(key_t k, logic [2:0] idx);
        logic [7:0] b;
        b = 8'h00;
        if (idx == MOD_BYTE) b = k.modifier;
        else if (idx == KEY_BYTE) b = k.keycode;
        return b;
    endfunction

endpackage

// File: rtl/usb_kbd_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer, wrapping.
module usb_kbd_rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [NREQ-1:0]         req,
    input  logic                    en,
    output logic [NREQ-1:0]         gnt,
    output logic [$clog2(NREQ)-1:0] gnt_idx,
    output logic                    gnt_any
);
    localparam int IW = $clog2(NREQ);

    logic [IW-1:0] ptr_q;

    always_comb begin
        int          j;
        logic [IW-1:0] k;
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        j       = 0;
        k       = '0;
        for (int i = 0; i < NREQ; i++) begin
            j = int'(ptr_q) + i;
            if (j >= NREQ) j = j - NREQ;
            k = IW'(j);
            if (en && !gnt_any && req[k]) begin
                gnt_any = 1'b1;
                gnt[k]  = 1'b1;
                gnt_idx = k;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr_q <= '0;
        end else if (gnt_any) begin
            ptr_q <= (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

endmodule

// File: rtl/usb_kbd_report_sched.sv
// Shares the EP81 boot-keyboard endpoint among NREQ key sources: press, gap, release, gap.
// Optional report counter output enabled by defining USB_KBD_REPORT_CNT_EN.
module usb_kbd_report_sched
    import usb_kbd_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int GAP_CYCLES = 60000
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    link_up,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [16*NREQ-1:0]      req_key,
    output logic [NREQ-1:0]         req_ready,
    output logic [7:0]              ep_data,
    output logic                    ep_valid,
    input  logic                    ep_ready,
    output logic                    busy,
    output logic [$clog2(NREQ)-1:0] grant_idx,
`ifdef USB_KBD_REPORT_CNT_EN
    output logic [15:0]             report_cnt,
`endif
    output state_t                  state_dbg
);
    localparam int            IW        = $clog2(NREQ);
    localparam int            GW        = $clog2(GAP_CYCLES + 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);
    localparam logic [2:0]    BYTE_LAST = 3'(REPORT_LEN - 1);

    state_t        state_q, state_d;
    logic [2:0]    byte_q, byte_d;
    logic [GW-1:0] gap_q, gap_d;
    key_t          key_q, key_d;
    logic [IW-1:0] grant_idx_q, grant_idx_d;

    logic [NREQ-1:0] arb_gnt;
    logic [IW-1:0]   arb_idx;
    logic            arb_any;
    key_t            sel_key;

    usb_kbd_rr_arbiter #(.NREQ(NREQ)) u_arb (
        .clk     (clk),
        .rstn    (rstn),
        .req     (req_valid),
        .en      (link_up && (state_q == IDLE)),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .gnt_any (arb_any)
    );

    always_comb begin
        sel_key = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (arb_gnt[i]) sel_key = key_t'(req_key[i*16 +: 16]);
        end
    end

    // Handshake: a byte moves on a cycle where ep_valid & ep_ready; ep_valid stays high and
    // ep_data stable for the whole report, and req_ready is a one-cycle accept in IDLE only.
    always_comb begin
        state_d     = state_q;
        byte_d      = byte_q;
        gap_d       = gap_q;
        key_d       = key_q;
        grant_idx_d = grant_idx_q;
        if (!link_up) begin
            state_d = IDLE;
            byte_d  = '0;
            gap_d   = '0;
            key_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (arb_any) begin
                        key_d       = sel_key;
                        grant_idx_d = arb_idx;
                        byte_d      = '0;
                        gap_d       = '0;
                        // An all-zero event is consumed without reports but still rate-limited.
                        state_d     = (sel_key == '0) ? GAP2 : PRESS;
                    end
                end
                PRESS, RELEASE: begin
                    if (ep_ready) begin
                        if (byte_q == BYTE_LAST) begin
                            byte_d  = '0;
                            state_d = (state_q == PRESS) ? GAP1 : GAP2;
                        end else begin
                            byte_d = byte_q + 3'd1;
                        end
                    end
                end
                GAP1, GAP2: begin
                    if (gap_q == GAP_LAST) begin
                        gap_d   = '0;
                        state_d = (state_q == GAP1) ? RELEASE : IDLE;
                    end else begin
                        gap_d = gap_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            byte_q      <= '0;
            gap_q       <= '0;
            key_q       <= '0;
            grant_idx_q <= '0;
        end else begin
            state_q     <= state_d;
            byte_q      <= byte_d;
            gap_q       <= gap_d;
            key_q       <= key_d;
            grant_idx_q <= grant_idx_d;
        end
    end

    assign ep_valid  = (state_q == PRESS) || (state_q == RELEASE);
    assign ep_data   = (state_q == PRESS) ? press_byte(key_q, byte_q) : 8'h00;
    assign busy      = (state_q != IDLE);
    assign req_ready = arb_gnt;
    assign grant_idx = grant_idx_q;
    assign state_dbg = state_q;

`ifdef USB_KBD_REPORT_CNT_EN
    logic [15:0] report_cnt_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            report_cnt_q <= '0;
        end else if ((state_q == PRESS) && ep_ready && (byte_q == BYTE_LAST)
                     && (report_cnt_q != 16'hFFFF)) begin
            report_cnt_q <= report_cnt_q + 16'd1;
        end
    end

    assign report_cnt = report_cnt_q;
`endif

endmodule

// File: tb/tb_usb_kbd_report_sched.sv
// Scoreboard bench for usb_kbd_report_sched (NREQ=4, GAP_CYCLES=4); covers USB_KBD_REPORT_CNT_EN when defined.
module tb_usb_kbd_report_sched;
    import usb_kbd_pkg::*;

    localparam int NREQ = 4;
    localparam int GAP  = 4;

    logic                    clk = 1'b0;
    logic                    rstn;
    logic                    link_up;
    logic [NREQ-1:0]         req_valid;
    logic [16*NREQ-1:0]      req_key;
    logic [NREQ-1:0]         req_ready;
    logic [7:0]              ep_data;
    logic                    ep_valid;
    logic                    ep_ready;
    logic                    busy;
    logic [$clog2(NREQ)-1:0] grant_idx;
    state_t                  state_dbg;
`ifdef USB_KBD_REPORT_CNT_EN
    logic [15:0]             report_cnt;
    logic [15:0]             exp_cnt;
`endif

    logic [15:0] keys [NREQ];

    always #5 clk = ~clk;

    always_comb begin
        req_key = '0;
        for (int i = 0; i < NREQ; i++) req_key[i*16 +: 16] = keys[i];
    end

    usb_kbd_report_sched #(.NREQ(NREQ), .GAP_CYCLES(GAP)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .link_up    (link_up),
        .req_valid  (req_valid),
        .req_key    (req_key),
        .req_ready  (req_ready),
        .ep_data    (ep_data),
        .ep_valid   (ep_valid),
        .ep_ready   (ep_ready),
        .busy       (busy),
        .grant_idx  (grant_idx),
`ifdef USB_KBD_REPORT_CNT_EN
        .report_cnt (report_cnt),
`endif
        .state_dbg  (state_dbg)
    );

    // Scoreboard: bit 8 marks the final byte of a press report.
    logic [8:0]      exp_q[$];
    int              grant_q[$];
    int              n_checks = 0;
    int              n_errors = 0;

    logic [NREQ-1:0] ack_pulse;
    logic            auto_drop, bp_mode, abort_skip;
    logic            prev_valid, prev_busy, prev_stall;
    logic [7:0]      prev_data;
    logic [3:0]      bp_pat;
    int              bp_i, low_busy, lat_pending, gidx_exp, hs_cnt;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int onehot_idx(input logic [NREQ-1:0] v);
        int r;
        r = -1;
        for (int i = 0; i < NREQ; i++) if (v[i] && r < 0) r = i;
        return r;
    endfunction

    task automatic push_event(input logic [15:0] k);
        exp_q.push_back({1'b0, k[15:8]});
        exp_q.push_back(9'h000);
        exp_q.push_back({1'b0, k[7:0]});
        for (int i = 0; i < 4; i++) exp_q.push_back(9'h000);
        exp_q.push_back(9'h100);
        for (int i = 0; i < 8; i++) exp_q.push_back(9'h000);
    endtask

    task automatic monitor();
        logic [8:0] e;
        int         g;
        ack_pulse = req_ready;
        if (lat_pending == 1) check("lat_valid", ep_valid, 1'b1);
        if (lat_pending == 2) begin
            check("empty_novalid", ep_valid, 1'b0);
            check("empty_gap2", state_dbg, GAP2);
        end
        if (lat_pending != 0) check("grant_idx", grant_idx, gidx_exp);
        lat_pending = 0;
        if (prev_stall && link_up) begin
            check("hold_valid", ep_valid, 1'b1);
            check("hold_data", ep_data, prev_data);
        end
        if (busy && !ep_valid) low_busy++;
        else if (ep_valid && !prev_valid && low_busy > 0) begin
            check("gap1_len", low_busy, GAP);
            low_busy = 0;
        end
        if (!busy && prev_busy) begin
            if (!abort_skip) check("gap2_len", low_busy, GAP);
            low_busy   = 0;
            abort_skip = 1'b0;
        end
        if (ep_valid && ep_ready) begin
            hs_cnt++;
            if (exp_q.size() == 0) check("extra_byte", exp_q.size(), 1);
            else begin
                e = exp_q.pop_front();
                check("ep_data", ep_data, e[7:0]);
`ifdef USB_KBD_REPORT_CNT_EN
                if (e[8] && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
`endif
            end
        end
        if (|req_ready) begin
            check("ready_onehot", $onehot(req_ready), 1'b1);
            check("ready_in_idle", state_dbg, IDLE);
            check("pair_done", exp_q.size(), 0);
            if (grant_q.size() == 0) check("extra_grant", grant_q.size(), 1);
            else begin
                g = grant_q.pop_front();
                check("grant", onehot_idx(req_ready), g);
                gidx_exp = g;
                if (keys[g] == 16'h0000) lat_pending = 2;
                else begin
                    lat_pending = 1;
                    push_event(keys[g]);
                end
            end
        end
        prev_valid = ep_valid;
        prev_busy  = busy;
        prev_stall = ep_valid && !ep_ready;
        prev_data  = ep_data;
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        if (auto_drop) req_valid = req_valid & ~ack_pulse;
        if (bp_mode) begin
            ep_ready = bp_pat[bp_i];
            bp_i     = (bp_i + 1) % 4;
        end
    endtask

    task automatic run_quiet(input int budget);
        logic done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            step();
            done = !busy && !prev_busy && exp_q.size() == 0 && grant_q.size() == 0
                   && req_valid == '0;
        end
        check("run_quiet_done", done, 1'b1);
    endtask

    task automatic single(input int idx, input logic [15:0] k);
        keys[idx] = k;
        grant_q.push_back(idx);
        req_valid[idx] = 1'b1;
        run_quiet(200);
    endtask

    initial begin
        int hs_base;
        rstn = 1'b0; link_up = 1'b1; req_valid = '0; ep_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) keys[i] = 16'h0000;
        auto_drop = 1'b1; bp_mode = 1'b0; abort_skip = 1'b0;
        prev_valid = 1'b0; prev_busy = 1'b0; prev_stall = 1'b0; prev_data = '0;
        bp_pat = 4'b1001; bp_i = 0; low_busy = 0; lat_pending = 0; gidx_exp = 0; hs_cnt = 0;
        ack_pulse = '0;
`ifdef USB_KBD_REPORT_CNT_EN
        exp_cnt = 16'd0;
`endif
        #12;
        check("rst_state", state_dbg, IDLE);
        check("rst_valid", ep_valid, 1'b0);
        check("rst_data", ep_data, 8'h00);
        check("rst_ready", req_ready, '0);
        check("rst_busy", busy, 1'b0);
        check("rst_gidx", grant_idx, 0);
        @(negedge clk); rstn = 1'b1;
        @(posedge clk); #1;

        // Contention: all of 0,1,3 held; strict rotation from pointer 0.
        keys[0] = 16'h0111; keys[1] = 16'h0005; keys[3] = 16'h2029;
        auto_drop = 1'b0;
        grant_q.push_back(0); grant_q.push_back(1); grant_q.push_back(3); grant_q.push_back(0);
        req_valid = 4'b1011;
        for (int i = 0; i < 300 && grant_q.size() != 0; i++) step();
        check("contention_grants", grant_q.size(), 0);
        req_valid = '0;
        auto_drop = 1'b1;
        run_quiet(200);

        single(0, 16'h0204);

        // Backpressure: ep_ready cycles 1,0,0,1.
        bp_mode = 1'b1; bp_i = 0;
        single(3, 16'h4016);
        bp_mode = 1'b0; ep_ready = 1'b1;

        single(2, 16'h0000);

        // Abort at PRESS byte 3.
        keys[0] = 16'h0105;
        grant_q.push_back(0);
        req_valid[0] = 1'b1;
        hs_base = hs_cnt;
        for (int i = 0; i < 50 && hs_cnt < hs_base + 3; i++) step();
        check("abort_reach_b3", hs_cnt - hs_base, 3);
        link_up = 1'b0; ep_ready = 1'b0;
        exp_q.delete();
        abort_skip = 1'b1;
        step();
        check("abort_valid", ep_valid, 1'b0);
        check("abort_state", state_dbg, IDLE);
        keys[1] = 16'h0207; keys[0] = 16'h0108;
        req_valid = 4'b0011;
        for (int i = 0; i < 3; i++) begin
            step();
            check("no_grant_linkdown", req_ready, '0);
        end
        grant_q.push_back(1); grant_q.push_back(0);
        link_up = 1'b1; ep_ready = 1'b1;
        run_quiet(200);

`ifdef USB_KBD_REPORT_CNT_EN
        check("cnt_cumulative", report_cnt, exp_cnt);
        single(0, 16'h0104); single(1, 16'h0006); single(2, 16'h0207);
        check("cnt_three_more", report_cnt, exp_cnt);
        force dut.report_cnt_q = 16'hFFFF;
        step();
        release dut.report_cnt_q;
        exp_cnt = 16'hFFFF;
        check("cnt_forced", report_cnt, exp_cnt);
        single(3, 16'h0009);
        check("cnt_saturate", report_cnt, exp_cnt);
        link_up = 1'b0; step(); link_up = 1'b1; step();
        check("cnt_linkdown", report_cnt, exp_cnt);
`endif

        check("final_exp_q", exp_q.size(), 0);
        check("final_grant_q", grant_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
